counter_serial_loader: RTL and testbench

//   Upstream load controller for the 8-bit counter. Receives a value over a slow
//   3-wire serial link (CS_N/SCK/SDI, asynchronous to CLK) and checks it.

---
 rtl/counter_serial_loader_if.sv | 16 +
 rtl/counter_serial_loader.sv | 156 +++++++++++++++
 tb/tb_counter_serial_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/counter_serial_loader_if.sv
// Serial-link inputs and counter-load outputs of the serial loader.
// master = link/counter side, slave = loader.
interface counter_serial_loader_if #(
  parameter int WIDTH = 8
);
  logic             CS_N;
  logic             SCK;
  logic             SDI;
  logic             LOAD;
  logic [WIDTH-1:0] VALUE;
  logic             BUSY;
  logic             ERR;

  modport master (output CS_N, SCK, SDI, input LOAD, VALUE, BUSY, ERR);
  modport slave  (input CS_N, SCK, SDI, output LOAD, VALUE, BUSY, ERR);
endinterface

// File: rtl/counter_serial_loader.sv
// Serial frame receiver that loads the counter; LOAD pulses 2 CLK after synced CS_N rise.
// No backpressure: the link is free-running and bad frames are dropped with ERR set.
module counter_serial_loader #(
  parameter int WIDTH       = 8,
  parameter bit PARITY_EN   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  counter_serial_loader_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, PARITY, WAIT_END, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic [SYNC_STAGES-1:0] flush_q, flush_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   armed_q, armed_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   par_q, par_d;
  logic                   ovr_q, ovr_d;
  logic                   err_q, err_d;
  logic                   load_q, load_d;
  logic [WIDTH-1:0]       value_q, value_d;

  logic cs_s, sck_s, sdi_s, flushed;
  logic cs_fall, cs_rise, sck_rise, par_err;

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign sck_s   = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s   = sdi_sync_q[SYNC_STAGES-1];
  assign flushed = flush_q[SYNC_STAGES-1];

  // CS_N edges only count once a genuine high level has come through the
  // synchronizer, so a CS_N held low across reset cannot start a frame.
  assign cs_fall  = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise  = armed_q & ~cs_prev_q & cs_s;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign par_err  = PARITY_EN ? ((^shift_q) ^ par_q) : 1'b0;

  always_comb begin
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], bus.CS_N};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.SCK};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.SDI};
    flush_d    = {flush_q[SYNC_STAGES-2:0], 1'b1};
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
    armed_d    = armed_q | (flushed & cs_s);
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    ovr_d      = ovr_q;
    err_d      = err_q;
    load_d     = 1'b0;
    value_d    = value_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          err_d   = 1'b0;
          cnt_d   = '0;
          shift_d = '0;
          par_d   = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d = {shift_q[WIDTH-2:0], sdi_s};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1))
            state_d = PARITY_EN ? PARITY : WAIT_END;
        end
      end
      PARITY: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          par_d   = sdi_s;
          state_d = WAIT_END;
        end
      end
      WAIT_END: begin
        if (cs_rise) begin
          if (ovr_q | par_err) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = COMMIT;
          end
        end else if (sck_rise) begin
          ovr_d = 1'b1;
        end
      end
      COMMIT: begin
        value_d = shift_q;
        load_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      flush_q    <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
      value_q    <= '0;
    end else begin
      state_q    <= state_d;
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      flush_q    <= flush_d;
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_prev_d;
      armed_q    <= armed_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
      load_q     <= load_d;
      value_q    <= value_d;
    end
  end

  assign bus.LOAD  = load_q;
  assign bus.VALUE = value_q;
  assign bus.ERR   = err_q;
  assign bus.BUSY  = (state_q != IDLE);
endmodule

// File: tb/tb_counter_serial_loader.sv
// Directed bench: one loader with parity, one without, fed the same serial stimulus.
module tb_counter_serial_loader;
  logic CLK;
  logic RESET;
  logic cs_n, sck, sdi;

  int checks   = 0;
  int failures = 0;
  int loads_a  = 0;
  int loads_b  = 0;
  int base;
  int since_load = 99;
  logic [7:0] cnt_c;
  logic [7:0] c_at1, c_at2;

  counter_serial_loader_if #(.WIDTH(8)) bus_a ();
  counter_serial_loader_if #(.WIDTH(8)) bus_b ();

  assign bus_a.CS_N = cs_n;
  assign bus_a.SCK  = sck;
  assign bus_a.SDI  = sdi;
  assign bus_b.CS_N = cs_n;
  assign bus_b.SCK  = sck;
  assign bus_b.SDI  = sdi;

  counter_serial_loader #(.WIDTH(8), .PARITY_EN(1'b1), .SYNC_STAGES(2)) u_dut_a (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus_a.slave)
  );

  counter_serial_loader #(.WIDTH(8), .PARITY_EN(1'b0), .SYNC_STAGES(2)) u_dut_b (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus_b.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // downstream counter fed by loader A
  always @(posedge CLK or posedge RESET) begin
    if (RESET)            cnt_c <= 8'h00;
    else if (bus_a.LOAD)  cnt_c <= bus_a.VALUE;
    else                  cnt_c <= cnt_c + 8'h01;
  end

  always @(negedge CLK) begin
    if (bus_a.LOAD) loads_a++;
    if (bus_b.LOAD) loads_b++;
    if (bus_a.LOAD) since_load = 0;
    else if (since_load < 3) since_load++;
    if (since_load == 1) c_at1 = cnt_c;
    if (since_load == 2) c_at2 = cnt_c;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic frame_begin();
    cs_n = 1'b0;
    wait_clk(10);
  endtask

  task automatic frame_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = v[i];
      wait_clk(6);
      sck = 1'b1;
      wait_clk(6);
      sck = 1'b0;
    end
  endtask

  task automatic frame_end();
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(12);
  endtask

  task automatic send(input logic [15:0] v, input int n);
    frame_begin();
    frame_bits(v, n);
    frame_end();
  endtask

  task automatic test_reset();
    RESET = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
    wait_clk(3);
    RESET = 1'b0;
    wait_clk(6);
    checks++; if (bus_a.LOAD !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", bus_a.LOAD); end
    checks++; if (bus_a.VALUE !== 8'h00) begin failures++; $display("FAIL reset_value got=%h exp=00", bus_a.VALUE); end
    checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_a.BUSY); end
    checks++; if (bus_a.ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_a.ERR); end
  endtask

  task automatic test_good_frame();
    base = loads_a; c_at1 = 8'h00; c_at2 = 8'h00;
    send({7'd0, 8'hA5, 1'b0}, 9);
    checks++; if (loads_a - base !== 1) begin failures++; $display("FAIL good_loads got=%0d exp=1", loads_a - base); end
    checks++; if (bus_a.VALUE !== 8'hA5) begin failures++; $display("FAIL good_value got=%h exp=a5", bus_a.VALUE); end
    checks++; if (bus_a.ERR !== 1'b0) begin failures++; $display("FAIL good_err got=%b exp=0", bus_a.ERR); end
    checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL good_busy got=%b exp=0", bus_a.BUSY); end
    checks++; if (c_at1 !== 8'hA5) begin failures++; $display("FAIL counter_load got=%h exp=a5", c_at1); end
    checks++; if (c_at2 !== 8'hA6) begin failures++; $display("FAIL counter_next got=%h exp=a6", c_at2); end
  endtask

  task automatic test_bad_parity();
    base = loads_a;
    send({7'd0, 8'h07, 1'b0}, 9);
    checks++; if (loads_a - base !== 0) begin failures++; $display("FAIL par_loads got=%0d exp=0", loads_a - base); end
    checks++; if (bus_a.ERR !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", bus_a.ERR); end
    checks++; if (bus_a.VALUE !== 8'hA5) begin failures++; $display("FAIL par_value got=%h exp=a5", bus_a.VALUE); end
    base = loads_a;
    frame_begin();
    checks++; if (bus_a.ERR !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus_a.ERR); end
    checks++; if (bus_a.BUSY !== 1'b1) begin failures++; $display("FAIL busy_frame got=%b exp=1", bus_a.BUSY); end
    frame_bits({7'd0, 8'h01, 1'b1}, 9);
    frame_end();
    checks++; if (bus_a.VALUE !== 8'h01) begin failures++; $display("FAIL par_next_value got=%h exp=01", bus_a.VALUE); end
    checks++; if (loads_a - base !== 1) begin failures++; $display("FAIL par_next_loads got=%0d exp=1", loads_a - base); end
  endtask

  task automatic test_short_frame();
    base = loads_a;
    send({11'd0, 5'b10110}, 5);
    checks++; if (bus_a.ERR !== 1'b1) begin failures++; $display("FAIL short_err got=%b exp=1", bus_a.ERR); end
    checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL short_busy got=%b exp=0", bus_a.BUSY); end
    checks++; if (bus_a.VALUE !== 8'h01) begin failures++; $display("FAIL short_value got=%h exp=01", bus_a.VALUE); end
    checks++; if (loads_a - base !== 0) begin failures++; $display("FAIL short_loads got=%0d exp=0", loads_a - base); end
  endtask

  task automatic test_overrun();
    base = loads_a;
    send({6'd0, 8'h3C, 2'b00}, 10);
    checks++; if (bus_a.ERR !== 1'b1) begin failures++; $display("FAIL ovr_err got=%b exp=1", bus_a.ERR); end
    checks++; if (loads_a - base !== 0) begin failures++; $display("FAIL ovr_loads got=%0d exp=0", loads_a - base); end
    checks++; if (bus_a.VALUE !== 8'h01) begin failures++; $display("FAIL ovr_value got=%h exp=01", bus_a.VALUE); end
  endtask

  task automatic test_reset_midframe();
    frame_begin();
    frame_bits({12'd0, 4'b1010}, 4);
    RESET = 1'b1;
    wait_clk(2);
    RESET = 1'b0;
    wait_clk(2);
    checks++; if (bus_a.LOAD !== 1'b0) begin failures++; $display("FAIL rst_mid_load got=%b exp=0", bus_a.LOAD); end
    checks++; if (bus_a.VALUE !== 8'h00) begin failures++; $display("FAIL rst_mid_value got=%h exp=00", bus_a.VALUE); end
    checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus_a.BUSY); end
    wait_clk(10);
    checks++; if (bus_a.BUSY !== 1'b0) begin failures++; $display("FAIL rst_cs_low_ignored got=%b exp=0", bus_a.BUSY); end
    cs_n = 1'b1;
    wait_clk(12);
    base = loads_a;
    send({7'd0, 8'hFF, 1'b0}, 9);
    checks++; if (bus_a.VALUE !== 8'hFF) begin failures++; $display("FAIL rst_next_value got=%h exp=ff", bus_a.VALUE); end
    checks++; if (loads_a - base !== 1) begin failures++; $display("FAIL rst_next_loads got=%0d exp=1", loads_a - base); end
  endtask

  task automatic test_no_parity();
    base = loads_b;
    send({8'd0, 8'h80}, 8);
    checks++; if (bus_b.VALUE !== 8'h80) begin failures++; $display("FAIL nopar_value got=%h exp=80", bus_b.VALUE); end
    checks++; if (loads_b - base !== 1) begin failures++; $display("FAIL nopar_loads got=%0d exp=1", loads_b - base); end
    checks++; if (bus_b.ERR !== 1'b0) begin failures++; $display("FAIL nopar_err got=%b exp=0", bus_b.ERR); end
    base = loads_b;
    send({7'd0, 8'h80, 1'b0}, 9);
    checks++; if (bus_b.ERR !== 1'b1) begin failures++; $display("FAIL nopar_ovr_err got=%b exp=1", bus_b.ERR); end
    checks++; if (loads_b - base !== 0) begin failures++; $display("FAIL nopar_ovr_loads got=%0d exp=0", loads_b - base); end
    checks++; if (bus_b.VALUE !== 8'h80) begin failures++; $display("FAIL nopar_ovr_value got=%h exp=80", bus_b.VALUE); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_short_frame();
    test_overrun();
    test_reset_midframe();
    test_no_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
